// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game controller state codes and result codes shared by game blocks
package game_pkg;

    localparam logic [6:0] GS_IDLE    = 7'h00;
    localparam logic [6:0] GS_ARM     = 7'h01;
    localparam logic [6:0] GS_REARM   = 7'h10;
    localparam logic [6:0] GS_TIMEOUT = 7'h12;
    localparam logic [6:0] GS_NEXT    = 7'h21;
    localparam logic [6:0] GS_END     = 7'h31;

    typedef enum logic [1:0] {
        RES_BUSY = 2'b00,
        RES_PASS = 2'b01,
        RES_FAIL = 2'b10,
        RES_END  = 2'b11
    } res_e;

    function automatic logic is_arm_code(input logic [6:0] code);
        return (code == GS_ARM) || (code == GS_REARM);
    endfunction

    function automatic logic is_release_code(input logic [6:0] code);
        return (code == GS_NEXT) || (code == GS_END);
    endfunction

endpackage

// File: rtl/result_hold_timer.sv
// rtl/result_hold_timer.sv - down-counter that times how long a pass/fail result is shown
module result_hold_timer #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] count;

    // Loaded on the edge that shows the result, so that edge counts as the first held cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(HOLD_CYCLES - 1);
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sequence_verifier.sv
// rtl/sequence_verifier.sv - collects a digit code entry, compares it to the armed secret and reports pass/fail
module sequence_verifier
    import game_pkg::*;
#(
    parameter int SEQ_LEN     = 4,
    parameter int DIGIT_W     = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  s_current,
    input  logic [DIGIT_W-1:0]          digit,
    input  logic                        digit_valid,
    input  logic [SEQ_LEN*DIGIT_W-1:0]  target,
    output logic [1:0]                  s_results,
    output logic [$clog2(SEQ_LEN+1)-1:0] entry_count
);

    localparam int CNT_W = $clog2(SEQ_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_PASS,
        ST_FAIL,
        ST_DONE
    } state_e;

    state_e                     state;
    logic [SEQ_LEN*DIGIT_W-1:0] target_q;
    logic [SEQ_LEN*DIGIT_W-1:0] entry_q;
    logic                       timeout;
    logic                       hold_load;
    logic                       hold_tick;
    logic                       hold_done;

    assign timeout   = (s_current == GS_TIMEOUT);
    assign hold_load = (state == ST_CHECK) || ((state == ST_ENTRY) && timeout);
    assign hold_tick = ((state == ST_PASS) || (state == ST_FAIL)) && !hold_done;

    result_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load),
        .tick (hold_tick),
        .done (hold_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            s_results   <= RES_BUSY;
            entry_count <= '0;
            entry_q     <= '0;
            target_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_arm_code(s_current)) begin
                        target_q    <= target;
                        entry_q     <= '0;
                        entry_count <= '0;
                        state       <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (timeout) begin
                        state     <= ST_FAIL;
                        s_results <= RES_FAIL;
                    end else if (digit_valid && (entry_count != CNT_W'(SEQ_LEN))) begin
                        // First digit lands in the most-significant slot, matching target.
                        for (int i = 0; i < SEQ_LEN; i++) begin
                            if (entry_count == CNT_W'(i)) begin
                                entry_q[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W] <= digit;
                            end
                        end
                        entry_count <= entry_count + 1'b1;
                        if (entry_count == CNT_W'(SEQ_LEN - 1)) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (!timeout && (entry_q == target_q)) begin
                        state     <= ST_PASS;
                        s_results <= RES_PASS;
                    end else begin
                        state     <= ST_FAIL;
                        s_results <= RES_FAIL;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (hold_done) begin
                        state     <= ST_DONE;
                        s_results <= RES_END;
                    end
                end
                ST_DONE: begin
                    if (is_release_code(s_current)) begin
                        state       <= ST_IDLE;
                        s_results   <= RES_BUSY;
                        entry_count <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    s_results <= RES_BUSY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_verifier.sv
// tb/tb_sequence_verifier.sv - directed self-checking bench for sequence_verifier
module tb_sequence_verifier;

    logic        clk;
    logic        rst;
    logic [6:0]  s_current;
    logic [3:0]  digit;
    logic        digit_valid;
    logic [15:0] target;
    logic [1:0]  s_results;
    logic [2:0]  entry_count;

    int total;
    int bad;

    sequence_verifier #(
        .SEQ_LEN    (4),
        .DIGIT_W    (4),
        .HOLD_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_current  (s_current),
        .digit      (digit),
        .digit_valid(digit_valid),
        .target     (target),
        .s_results  (s_results),
        .entry_count(entry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [6:0] code, input logic [15:0] tgt);
        target    = tgt;
        s_current = code;
        @(negedge clk);
        s_current = 7'h00;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    // Called one cycle after the edge that showed the result.
    task automatic hold_check(input string tag, input logic [1:0] exp_res);
        for (int i = 0; i < 8; i++) begin
            check(tag, 32'(s_results), 32'(exp_res));
            @(negedge clk);
        end
        check({tag, "_end"}, 32'(s_results), 32'h3);
    endtask

    task automatic release_to_idle(input logic [6:0] code);
        s_current = code;
        @(negedge clk);
        s_current = 7'h00;
        check("release_res", 32'(s_results), 32'h0);
        check("release_cnt", 32'(entry_count), 32'h0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        s_current   = 7'h00;
        digit       = 4'h0;
        digit_valid = 1'b0;
        target      = 16'h0000;
        @(negedge clk);
        check("reset_res", 32'(s_results), 32'h0);
        check("reset_cnt", 32'(entry_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Correct entry passes
        arm(7'h01, 16'h1234);
        enter_digit(4'h1);
        check("cnt_after_1", 32'(entry_count), 32'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        check("cnt_after_4", 32'(entry_count), 32'h4);
        check("busy_in_check", 32'(s_results), 32'h0);
        @(negedge clk);
        hold_check("pass_hold", 2'b01);
        release_to_idle(7'h21);

        // Wrong last digit fails
        arm(7'h01, 16'h1234);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h5);
        @(negedge clk);
        hold_check("fail_hold", 2'b10);
        release_to_idle(7'h31);

        // Timeout after two digits
        arm(7'h10, 16'h1234);
        enter_digit(4'h1);
        enter_digit(4'h2);
        s_current = 7'h12;
        @(negedge clk);
        s_current = 7'h00;
        check("timeout_cnt", 32'(entry_count), 32'h2);
        hold_check("timeout_hold", 2'b10);
        check("timeout_cnt_done", 32'(entry_count), 32'h2);
        release_to_idle(7'h21);

        // Timeout overrides a digit arriving in the same cycle
        arm(7'h01, 16'h1234);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        s_current   = 7'h12;
        digit       = 4'h4;
        digit_valid = 1'b1;
        @(negedge clk);
        s_current   = 7'h00;
        digit_valid = 1'b0;
        check("ovr_cnt", 32'(entry_count), 32'h3);
        hold_check("ovr_hold", 2'b10);
        release_to_idle(7'h31);

        // Ignored digits outside entry, target change after arming
        enter_digit(4'h7);
        check("idle_dv_res", 32'(s_results), 32'h0);
        check("idle_dv_cnt", 32'(entry_count), 32'h0);
        s_current = 7'h55;
        @(negedge clk);
        s_current = 7'h00;
        enter_digit(4'h1);
        check("unknown_code_cnt", 32'(entry_count), 32'h0);
        arm(7'h01, 16'h1234);
        enter_digit(4'h1);
        enter_digit(4'h2);
        target = 16'hFFFF;
        enter_digit(4'h3);
        enter_digit(4'h4);
        @(negedge clk);
        hold_check("retarget_hold", 2'b01);
        enter_digit(4'h9);
        check("done_dv_res", 32'(s_results), 32'h3);
        check("done_dv_cnt", 32'(entry_count), 32'h4);
        release_to_idle(7'h21);

        // Asynchronous reset mid-pass
        arm(7'h01, 16'h1234);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_res", 32'(s_results), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_res", 32'(s_results), 32'h0);
        check("async_rst_cnt", 32'(entry_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        enter_digit(4'h1);
        check("post_rst_idle_cnt", 32'(entry_count), 32'h0);
        target = 16'h5678;
        arm(7'h10, 16'h5678);
        enter_digit(4'h5);
        enter_digit(4'h6);
        enter_digit(4'h7);
        enter_digit(4'h8);
        @(negedge clk);
        hold_check("rearm_hold", 2'b01);

        // Arming code while in DONE does nothing
        s_current = 7'h10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("done_hold_10", 32'(s_results), 32'h3);
        end
        release_to_idle(7'h31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_verifier.md
SEQUENCE_VERIFIER -- requirements
Module: sequence_verifier

Interface
REQ-001 Parameter SEQ_LEN, 4, number of digits per code entry (2..8).
REQ-002 Parameter DIGIT_W, 4, bits per digit.
REQ-003 Parameter HOLD_CYCLES, 8, cycles the pass/fail result is held before the end code.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_current  input  7  game state code from the game controller.
REQ-007 digit  input  DIGIT_W  player digit.
REQ-008 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-009 target  input  SEQ_LEN*DIGIT_W  secret code; first digit in the most-significant DIGIT_W bits.
REQ-010 s_results  output  2  result code to the game controller: 00 busy, 01 pass, 10 fail, 11 sequence end.
REQ-011 entry_count  output  clog2(SEQ_LEN+1)  digits accepted so far in the current entry.

Function
REQ-012 The block SHALL be a registered FSM with states IDLE, ENTRY, CHECK, PASS, FAIL, DONE; all outputs registered.
REQ-013 IDLE: s_results=00, entry_count=0; on s_current==7'h01 or 7'h10, SHALL latch target and go to ENTRY.
REQ-014 ENTRY: each cycle with digit_valid=1 SHALL store digit at position entry_count and increment entry_count.
REQ-015 ENTRY: the SEQ_LEN-th accepted digit SHALL move the FSM to CHECK on the same edge; no further digits accepted.
REQ-016 CHECK: one cycle; compare all stored digits with latched target; equal -> PASS, else -> FAIL; s_results updates on that edge (2 edges after the last digit).
REQ-017 PASS drives s_results=01, FAIL drives 10, each for exactly HOLD_CYCLES cycles, then DONE.
REQ-018 DONE: s_results=11; hold until s_current==7'h21 or 7'h31, then IDLE with s_results=00 and entry_count=0.
REQ-019 Timeout: s_current==7'h12 while in ENTRY or CHECK SHALL force FAIL on the next edge, overriding any digit or compare in that cycle.
REQ-020 digit_valid outside ENTRY SHALL be ignored with no state change.
REQ-021 Changes on target after arming SHALL have no effect until the next IDLE->ENTRY transition.
REQ-022 s_current codes not named above SHALL cause no transition.
REQ-023 entry_count SHALL saturate at SEQ_LEN and never wrap.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, s_results=00, entry_count=0, clear stored digits and the hold counter, regardless of state or clock.
REQ-025 After rst deasserts, the block SHALL wait in IDLE for an arming code; mid-entry digits are lost.

Structure
REQ-026 A shared package game_pkg SHALL hold the s_current codes (7'h00, 7'h01, 7'h10, 7'h12, 7'h21, 7'h31) and s_results codes (RES_BUSY, RES_PASS, RES_FAIL, RES_END).
REQ-027 The FSM state encoding SHALL be local to sequence_verifier.
REQ-028 The HOLD_CYCLES down-counter SHALL be a sub-module result_hold_timer (load, tick, done) instantiated once.

Verification
REQ-029 target=16'h1234, s_current=7'h01, digits 1,2,3,4 on consecutive cycles -> s_results=01 two edges after digit 4, held 8 cycles, then 11; s_current=7'h21 -> 00.
REQ-030 target=16'h1234, digits 1,2,3,5 -> s_results=10 for 8 cycles, then 11; s_current=7'h31 -> 00, entry_count=0.
REQ-031 Digits 1,2 entered, then s_current=7'h12 -> s_results=10 next edge, entry_count frozen at 2, then 11 after 8 cycles.
REQ-032 digit_valid pulses in IDLE and DONE, and target changed to 16'hFFFF mid-entry -> no state change; correct 1,2,3,4 still passes.
REQ-033 rst asserted asynchronously mid-PASS -> s_results=00 and entry_count=0 before next clk edge; re-arm and pass again.
REQ-034 s_current held at 7'h10 during DONE for 20 cycles -> s_results remains 11 throughout.
